// File: rtl/montgomery_pkg.sv
// Shared types and constants for the parametrised Montgomery multiplier.
package montgomery_pkg;

  // Default operand/modulus width; also the Montgomery exponent (R = 2^WIDTH).
  localparam int MONT_WIDTH_DEFAULT = 1024;

  // Operation sequence: IDLE -> LOOP -> SUB -> DONE -> IDLE.
  // An even modulus skips straight from IDLE to DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } mont_state_e;

endpackage

// File: rtl/mont_cond_sub.sv
// Final conditional subtraction: brings the loop accumulator C (< 2m) into [0, m).
module mont_cond_sub
  import montgomery_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH_DEFAULT
) (
  input  logic [WIDTH+1:0] c,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r
);

  logic ge;

  // Compare at full accumulator width; when c >= m the difference is < m,
  // so only the low WIDTH bits of the subtraction are ever needed.
  always_comb begin
    ge = (c >= {2'b00, m});
    r  = ge ? (c[WIDTH-1:0] - m) : c[WIDTH-1:0];
  end

endmodule

// File: rtl/montgomery_mult_param.sv
// Radix-2 Montgomery multiplier: result = in_a * in_b * 2^-WIDTH mod in_m.
// start/done handshake: start is sampled only while IDLE; operands are latched
// on the accepting edge and later input changes are ignored. done is a
// one-cycle pulse marking result/err valid; busy covers LOOP and SUB.
module montgomery_mult_param
  import montgomery_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mont_state_e      state;
  mont_state_e      state_next;

  logic [WIDTH-1:0] a_sh;        // multiplicand, consumed LSB-first
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] sub_r;
  logic [WIDTH+1:0] c_r;         // accumulator, kept below 2m
  logic [WIDTH+1:0] c_next;
  logic [WIDTH+1:0] m_half_inc;  // (m >> 1) + 1
  logic [WIDTH+2:0] t_sum;       // C + a_i*b, one spare bit of headroom
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_iter;
  logic             err_r;

  assign accept    = (state == IDLE) && start;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // One Montgomery iteration. For odd T and odd m, (T + m) / 2 equals
  // (T >> 1) + (m >> 1) + 1, which avoids building and then discarding
  // the always-zero LSB of T + m.
  always_comb begin
    t_sum      = {1'b0, c_r} + {3'b000, (a_sh[0] ? b_r : '0)};
    m_half_inc = {3'b000, m_r[WIDTH-1:1]} + (WIDTH + 2)'(1);
    c_next     = t_sum[WIDTH+2:1] + (t_sum[0] ? m_half_inc : '0);
  end

  mont_cond_sub #(
    .WIDTH (WIDTH)
  ) u_cond_sub (
    .c (c_r),
    .m (m_r),
    .r (sub_r)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; an even modulus is reported without running the loop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = in_m[0] ? LOOP : DONE;
        end
      end
      LOOP: begin
        if (last_iter) begin
          state_next = SUB;
        end
      end
      SUB:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latches, accumulator, iteration counter and result/err holding.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_sh     <= '0;
      b_r      <= '0;
      m_r      <= '0;
      c_r      <= '0;
      cnt      <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else if (accept) begin
      a_sh     <= in_a;
      b_r      <= in_b;
      m_r      <= in_m;
      c_r      <= '0;
      cnt      <= '0;
      result_r <= '0;
      err_r    <= ~in_m[0];
    end else if (state == LOOP) begin
      c_r  <= c_next;
      a_sh <= a_sh >> 1;
      cnt  <= cnt + CNT_W'(1);
    end else if (state == SUB) begin
      result_r <= sub_r;
    end
  end

  // Status is a pure decode of the state, so reset clears it immediately.
  always_comb begin
    done   = (state == DONE);
    busy   = (state == LOOP) || (state == SUB);
    result = result_r;
    err    = err_r;
  end

endmodule
